uart_tx_fifo_p: RTL and testbench

//  Parametrised UART transmitter: next generation of the tester's fixed 6-bit TX.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 50 +++++
 rtl/uart_tx_fifo_p.sv | 145 ++++++++++++++
 tb/tb_uart_tx_fifo_p.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock word FIFO with occupancy count; the caller guarantees legal push/pop.
module uart_sync_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata_c,
  output logic              full_c,
  output logic              empty_c,
  output logic [CNT_W-1:0]  cnt
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge in_clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata_c = mem[rd_ptr];
  assign full_c  = (cnt == CNT_W'(FIFO_DEPTH));
  assign empty_c = (cnt == '0);

endmodule

// File: rtl/uart_tx_fifo_p.sv
// Buffered UART transmitter: FIFO-fed, LSB-first frames with optional parity
// and 1/2 stop bits, back-to-back frames when words are queued.
module uart_tx_fifo_p
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CLK_DIV    = 243,
  parameter parity_e     PARITY     = PAR_NONE,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              out_ready,
  output logic              out_tx,
  output logic              out_busy,
  output logic              out_done,
  output logic [CNT_W-1:0]  out_fifo_cnt
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(DATA_W);

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  div_q;
  logic [BIT_W-1:0]  bit_q;
  logic              stop_q;
  logic [DATA_W-1:0] shreg_q;
  logic              par_q;
  logic              tx_q, done_q, busy_q;

  logic              push_c, pop_c, tx_c, done_c;
  logic              tick_c, last_bit_c, last_stop_c;
  logic              full_c, empty_c;
  logic [DATA_W-1:0] rdata_c;

  assign push_c      = in_valid & ~full_c;
  assign tick_c      = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_bit_c  = (bit_q == BIT_W'(DATA_W - 1));
  assign last_stop_c = (stop_q == 1'(STOP_BITS - 1));

  uart_sync_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .in_clk  (in_clk),
    .in_rst_n(in_rst_n),
    .push    (push_c),
    .wdata   (in_data),
    .pop     (pop_c),
    .rdata_c (rdata_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .cnt     (out_fifo_cnt)
  );

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next state, pop request and the line level for the current bit.
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    done_c  = 1'b0;
    tx_c    = STOP_BIT;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_c = START_BIT;
        if (tick_c) state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_c = shreg_q[0];
        if (tick_c && last_bit_c) begin
          if (PARITY != PAR_NONE) state_d = ST_PARITY;
          else                    state_d = ST_STOP;
        end
      end
      ST_PARITY: begin
        tx_c = par_q;
        if (tick_c) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick_c && last_stop_c) begin
          done_c = 1'b1;
          if (!empty_c) begin
            pop_c   = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit timing, shift register and registered line outputs.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      div_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= STOP_BIT;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tx_q   <= tx_c;
      done_q <= done_c;
      busy_q <= (state_q != ST_IDLE);
      if (pop_c || state_q == ST_IDLE || tick_c) div_q <= '0;
      else                                       div_q <= div_q + DIV_W'(1);
      if (state_q == ST_DATA && tick_c) begin
        bit_q <= last_bit_c ? '0 : bit_q + BIT_W'(1);
      end
      if (state_q == ST_STOP && tick_c) begin
        stop_q <= last_stop_c ? 1'b0 : ~stop_q;
      end
      if (pop_c) begin
        shreg_q <= rdata_c;
        par_q   <= (PARITY == PAR_ODD) ? ~^rdata_c : ^rdata_c;
      end else if (state_q == ST_DATA && tick_c) begin
        shreg_q <= shreg_q >> 1;
      end
    end
  end

  assign out_ready = ~full_c;
  assign out_tx    = tx_q;
  assign out_busy  = busy_q;
  assign out_done  = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_p.sv
// Scoreboard bench for uart_tx_fifo_p across four parameter sets sharing one clock/reset.
module tb_uart_tx_fifo_p;
  import uart_pkg::*;

  typedef struct {
    logic [31:0] bits;
    int          nb;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a_v, b_v, c_v, d_v;
  logic [7:0] a_d, b_d, c_d;
  logic [4:0] d_d;
  wire  [3:0] tx_all, busy_all, done_all, ready_all;
  wire  [2:0] a_cnt, b_cnt, c_cnt, d_cnt;

  int cfg_dw  [4] = '{8, 8, 8, 5};
  int cfg_par [4] = '{0, 1, 2, 0};
  int cfg_sb  [4] = '{1, 1, 1, 2};
  int cfg_div [4] = '{4, 4, 4, 2};

  frame_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  uart_tx_fifo_p #(.DATA_W(8), .CLK_DIV(4), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .in_clk(clk), .in_rst_n(rst_n), .in_data(a_d), .in_valid(a_v), .out_ready(ready_all[0]),
    .out_tx(tx_all[0]), .out_busy(busy_all[0]), .out_done(done_all[0]), .out_fifo_cnt(a_cnt));
  uart_tx_fifo_p #(.DATA_W(8), .CLK_DIV(4), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .in_clk(clk), .in_rst_n(rst_n), .in_data(b_d), .in_valid(b_v), .out_ready(ready_all[1]),
    .out_tx(tx_all[1]), .out_busy(busy_all[1]), .out_done(done_all[1]), .out_fifo_cnt(b_cnt));
  uart_tx_fifo_p #(.DATA_W(8), .CLK_DIV(4), .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .in_clk(clk), .in_rst_n(rst_n), .in_data(c_d), .in_valid(c_v), .out_ready(ready_all[2]),
    .out_tx(tx_all[2]), .out_busy(busy_all[2]), .out_done(done_all[2]), .out_fifo_cnt(c_cnt));
  uart_tx_fifo_p #(.DATA_W(5), .CLK_DIV(2), .PARITY(PAR_NONE), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
    .in_clk(clk), .in_rst_n(rst_n), .in_data(d_d), .in_valid(d_v), .out_ready(ready_all[3]),
    .out_tx(tx_all[3]), .out_busy(busy_all[3]), .out_done(done_all[3]), .out_fifo_cnt(d_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bits.
  function automatic frame_t mk_frame(input logic [8:0] w, input int idx);
    frame_t f;
    int     p;
    logic   x;
    f.bits = '0;
    p = 1;
    x = 1'b0;
    for (int i = 0; i < cfg_dw[idx]; i++) begin
      f.bits[p] = w[i];
      x = x ^ w[i];
      p++;
    end
    if (cfg_par[idx] == 1) begin f.bits[p] = x;  p++; end
    if (cfg_par[idx] == 2) begin f.bits[p] = ~x; p++; end
    for (int s = 0; s < cfg_sb[idx]; s++) begin
      f.bits[p] = 1'b1;
      p++;
    end
    f.nb = p;
    return f;
  endfunction

  task automatic set_in(input int idx, input logic [8:0] w, input logic v);
    case (idx)
      0: begin a_v = v; a_d = w[7:0]; end
      1: begin b_v = v; b_d = w[7:0]; end
      2: begin c_v = v; c_d = w[7:0]; end
      default: begin d_v = v; d_d = w[4:0]; end
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push_w(input int idx, input logic [8:0] w, input bit to_sb, output int acc);
    int tries = 0;
    acc = -1;
    set_in(idx, w, 1'b1);
    while (ready_all[idx] !== 1'b1 && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 200) begin
      chk("push_timeout", 32'(tries), 32'd0);
      set_in(idx, w, 1'b0);
      return;
    end
    acc = cyc + 1;
    if (to_sb) sb_q.push_back(mk_frame(w, idx));
    @(negedge clk);
    set_in(idx, w, 1'b0);
  endtask

  // Waits for a start bit, then samples every cycle of the frame.
  task automatic rx_frame(input int idx, input string tag, output int gap, output int st);
    frame_t      e;
    logic [31:0] got;
    int          bad_lvl, bad_done, bad_busy, div;
    gap = 0;
    st  = -1;
    div = cfg_div[idx];
    @(negedge clk);
    while (tx_all[idx] !== 1'b0 && gap < 400) begin
      @(negedge clk);
      gap++;
    end
    if (gap >= 400) begin
      chk({tag, "_start_timeout"}, 32'(gap), 32'd0);
      return;
    end
    st = cyc;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    got = '0;
    bad_lvl = 0; bad_done = 0; bad_busy = 0;
    for (int b = 0; b < e.nb; b++) begin
      for (int c = 0; c < div; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (c == 0) got[b] = tx_all[idx];
        else if (tx_all[idx] !== got[b]) bad_lvl++;
        if (done_all[idx] !== ((b == e.nb - 1) && (c == div - 1))) bad_done++;
        if (busy_all[idx] !== 1'b1) bad_busy++;
      end
    end
    chk({tag, "_bits"}, got, e.bits);
    chk({tag, "_bit_width"}, 32'(bad_lvl), 32'd0);
    chk({tag, "_done_pos"}, 32'(bad_done), 32'd0);
    chk({tag, "_busy"}, 32'(bad_busy), 32'd0);
  endtask

  task automatic chk_idle(input int idx, input string tag);
    @(negedge clk);
    chk({tag, "_idle_tx"}, 32'(tx_all[idx]), 32'd1);
    chk({tag, "_idle_busy"}, 32'(busy_all[idx]), 32'd0);
    chk({tag, "_idle_done"}, 32'(done_all[idx]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t expected finish before 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, acc1, acc3, acc6, gap, st, bad;
    logic [8:0] w3 [6];
    w3 = '{9'h11, 9'h22, 9'h3C, 9'h5A, 9'hC3, 9'hF0};
    rst_n = 1'b0;
    a_v = 1'b0; b_v = 1'b0; c_v = 1'b0; d_v = 1'b0;
    a_d = '0; b_d = '0; c_d = '0; d_d = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_tx", 32'(tx_all), 32'hF);
    chk("rst_busy", 32'(busy_all), 32'h0);
    chk("rst_done", 32'(done_all), 32'h0);
    chk("rst_cnt", {20'd0, a_cnt, b_cnt, c_cnt, d_cnt}, 32'd0);
    chk("rst_ready", 32'(ready_all), 32'hF);

    // 0xA5, no parity: latency and bit pattern
    fork
      push_w(0, 9'h0A5, 1'b1, acc0);
      rx_frame(0, "t1", gap, st);
    join
    chk("t1_latency", 32'(st), 32'(acc0 + 2));
    chk_idle(0, "t1");

    // parity, 0x07: even -> 1, odd -> 0
    fork
      push_w(1, 9'h007, 1'b1, acc0);
      rx_frame(1, "t2_even", gap, st);
    join
    chk_idle(1, "t2_even");
    fork
      push_w(2, 9'h007, 1'b1, acc0);
      rx_frame(2, "t2_odd", gap, st);
    join
    chk_idle(2, "t2_odd");

    // six back-to-back words into a depth-4 FIFO
    fork
      begin
        push_w(0, w3[0], 1'b1, acc1);
        push_w(0, w3[1], 1'b1, acc0);
        chk("t3_cnt_after_pop", 32'(a_cnt), 32'd1);
        push_w(0, w3[2], 1'b1, acc0);
        push_w(0, w3[3], 1'b1, acc0);
        push_w(0, w3[4], 1'b1, acc0);
        chk("t3_ready_full", 32'(ready_all[0]), 32'd0);
        chk("t3_cnt_full", 32'(a_cnt), 32'd4);
        push_w(0, w3[5], 1'b1, acc6);
        chk("t3_sixth_accept", 32'(acc6 - acc1), 32'd42);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          rx_frame(0, "t3", gap, st);
          if (i > 0) chk("t3_gap", 32'(gap), 32'd0);
        end
      end
    join
    chk_idle(0, "t3");

    // push coinciding with a pop at count 2
    fork
      begin
        push_w(0, 9'h0E1, 1'b1, acc0);
        push_w(0, 9'h01E, 1'b1, acc1);
        push_w(0, 9'h077, 1'b1, acc1);
        chk("t4_cnt2", 32'(a_cnt), 32'd2);
        while (cyc < acc0 + 40) @(negedge clk);
        chk("t4_cnt_pre", 32'(a_cnt), 32'd2);
        push_w(0, 9'h0B4, 1'b1, acc3);
        chk("t4_push_at_pop", 32'(acc3), 32'(acc0 + 41));
        chk("t4_cnt_post", 32'(a_cnt), 32'd2);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          rx_frame(0, "t4", gap, st);
          if (i > 0) chk("t4_gap", 32'(gap), 32'd0);
        end
      end
    join
    chk_idle(0, "t4");

    // reset in the middle of data bit 3 with a second word queued
    push_w(0, 9'h03C, 1'b0, acc0);
    push_w(0, 9'h081, 1'b0, acc1);
    while (cyc < acc0 + 18) @(negedge clk);
    chk("t5_busy_pre", 32'(busy_all[0]), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_tx", 32'(tx_all[0]), 32'd1);
    chk("t5_busy", 32'(busy_all[0]), 32'd0);
    chk("t5_cnt", 32'(a_cnt), 32'd0);
    chk("t5_done", 32'(done_all[0]), 32'd0);
    chk("t5_ready", 32'(ready_all[0]), 32'd1);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_all[0] !== 1'b1 || done_all[0] !== 1'b0 || busy_all[0] !== 1'b0) bad++;
    end
    chk("t5_quiet", 32'(bad), 32'd0);
    fork
      push_w(0, 9'h096, 1'b1, acc0);
      rx_frame(0, "t5_new", gap, st);
    join
    chk("t5_latency", 32'(st), 32'(acc0 + 2));
    chk_idle(0, "t5");

    // 5 data bits, 2 stop bits, divide by 2
    fork
      push_w(3, 9'h01F, 1'b1, acc0);
      rx_frame(3, "t6", gap, st);
    join
    chk_idle(3, "t6");

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
